gpr_file: RTL and testbench
===========================

// Module: gpr_file
// PURPOSE
//  Parametrised integer register file with a per-register pending-write scoreboard.
//  Sits between decode (reads operands, issues destinations) and writeback (retires results).
//  Gives decode operand data plus a busy flag per read port, so decode can stall on RAW hazards.
// PARAMETERS
//  XLEN   64  data width of each register
//  NREG   32  number of registers; index 0 hardwired to zero; power of 2, >= 2
//  NRD    2   number of read ports, 1..4
//  AW     $clog2(NREG)  address width (derived, localparam)
// PORTS
//  clk           in   1          clock
//  rst           in   1          asynchronous reset, active-low
//  rd_addr[NRD]  in   NRD x AW   read addresses
//  rd_data[NRD]  out  NRD x XLEN read data (combinational)
//  rd_busy[NRD]  out  NRD        addressed register has a write pending
//  iss_valid     in   1          decode issues an instruction writing iss_addr
//  iss_addr      in   AW         destination register being issued
//  we            in   1          writeback valid
//  wr_addr       in   AW         writeback destination
//  wr_data       in   XLEN       writeback data
//  busy_cnt      out  AW+1       number of registers currently marked busy (registered)
// BEHAVIOUR
//  Reset (rst=0, async): all registers -> 0, all busy bits -> 0, busy_cnt -> 0.
//    Reset mid-operation discards pending writes; no write occurs on the reset edge.
//  Register 0: reads always return 0 with rd_busy=0. Writes and issues to addr 0 are ignored;
//    they never set busy or change busy_cnt.
//  Write: on posedge clk with we=1 and wr_addr!=0, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
//  Issue: on posedge clk with iss_valid=1 and iss_addr!=0, busy[iss_addr] <= 1.
//  Same-cycle issue and write to the same register: issue wins and busy stays 1 (new producer).
//    Data is still written.
//  Issue to a register that is already busy: busy stays 1, busy_cnt unchanged.
//  Write to a register that is not busy: data is written, busy stays 0 (permitted, no error).
//  busy_cnt equals the popcount of busy[] after each edge. Update by +1/-1/0 from the
//    set/clear events (max NREG-1); do not recompute a full popcount.
//  Reads: rd_data[i] = reg[rd_addr[i]] and rd_busy[i] = busy[rd_addr[i]], zero-cycle latency.
//    Read ports are independent; any ports may address the same register.
// CONFIGURATION
//  GPR_BYPASS_EN defined:
//    If we=1 and wr_addr==rd_addr[i]!=0, then rd_data[i]=wr_data and rd_busy[i]=0 in the same cycle.
//    Exception: if iss_valid targets the same register in that cycle, rd_busy[i] still reflects
//    the old busy state, not the new issue.
//  GPR_BYPASS_EN undefined: reads see pre-edge state only; written data is visible next cycle.
// STRUCTURE
//  gpr_pkg: XLEN default, typedef gpr_addr_t (logic [AW-1:0] for NREG=32), typedef gpr_data_t,
//    localparam GPR_ZERO = '0.
//  Sub-module gpr_scoreboard: busy[] vector, issue/write set-clear priority, busy_cnt counter,
//    NRD busy lookups.
//  Top: register array (generate over 1..NREG-1), read muxes, bypass logic.
// TESTING
//  1 Reset then read all regs on every port -> every rd_data=0, every rd_busy=0, busy_cnt=0.
//  2 iss x5; next cycle we x5=64'hDEAD_BEEF -> rd_busy x5 is 1 then 0; read x5=DEAD_BEEF;
//    busy_cnt goes 0->1->0.
//  3 Same cycle: iss x7 and we x7=64'h1 -> next cycle x7=1, rd_busy x7=1, busy_cnt=1.
//  4 we x0=64'hFFFF, iss x0 -> x0 reads 0, rd_busy=0, busy_cnt unchanged.
//  5 With GPR_BYPASS_EN: we x3=64'hA5 while rd_addr[0]=rd_addr[1]=3 -> both ports read 64'hA5
//    that cycle. Without it: old value that cycle, 64'hA5 next cycle.
//  6 iss x1..x31 on consecutive cycles; assert rst low mid-sequence -> busy_cnt and all regs
//    are 0 immediately (async); after release there is no residual busy.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared defaults and types for the integer register file with pending-write scoreboard.
package gpr_pkg;

   localparam int GPR_XLEN = 64;
   localparam int GPR_NREG = 32;
   localparam int GPR_NRD  = 2;
   localparam int GPR_AW   = $clog2(GPR_NREG);

   typedef logic [GPR_AW-1:0]   gpr_addr_t;
   typedef logic [GPR_XLEN-1:0] gpr_data_t;

   localparam gpr_data_t GPR_ZERO = '0;

endpackage

// File: rtl/gpr_if.sv
// Register-file bus: operand reads with busy flags, destination issue, writeback.
interface gpr_if
   import gpr_pkg::*;
#(
   parameter int XLEN = GPR_XLEN,
   parameter int NREG = GPR_NREG,
   parameter int NRD  = GPR_NRD
);

   localparam int AW = $clog2(NREG);

   logic [NRD-1:0][AW-1:0]   rd_addr;
   logic [NRD-1:0][XLEN-1:0] rd_data;
   logic [NRD-1:0]           rd_busy;
   logic                     iss_valid;
   logic [AW-1:0]            iss_addr;
   logic                     we;
   logic [AW-1:0]            wr_addr;
   logic [XLEN-1:0]          wr_data;
   logic [AW:0]              busy_cnt;

   // Decode/writeback side drives addresses and commands.
   modport master (
      output rd_addr, iss_valid, iss_addr, we, wr_addr, wr_data,
      input  rd_data, rd_busy, busy_cnt
   );

   modport slave (
      input  rd_addr, iss_valid, iss_addr, we, wr_addr, wr_data,
      output rd_data, rd_busy, busy_cnt
   );

endinterface

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: per-register busy bits, incremental busy count, per-port lookup.
// With GPR_BYPASS_EN defined, a same-cycle writeback clears the reported busy flag.
module gpr_scoreboard
   import gpr_pkg::*;
#(
   parameter  int NREG = GPR_NREG,
   parameter  int NRD  = GPR_NRD,
   localparam int AW   = $clog2(NREG)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   iss_valid_i,
   input  logic [AW-1:0]          iss_addr_i,
   input  logic                   we_i,
   input  logic [AW-1:0]          wr_addr_i,
   input  logic [NRD-1:0][AW-1:0] rd_addr_i,
   output logic [NRD-1:0]         rd_busy_o,
   output logic [AW:0]            busy_cnt_o
);

   logic            iss_en;
   logic            wr_en;
   logic [NREG-1:0] busy_vec;
   logic            set_new;
   logic            clr_old;
   logic [AW:0]     busy_cnt_q;
   logic [AW:0]     busy_cnt_d;

   assign iss_en = iss_valid_i && (iss_addr_i != '0);
   assign wr_en  = we_i && (wr_addr_i != '0);

   assign busy_vec[0] = 1'b0;

   genvar gi;
   for (gi = 1; gi < NREG; gi++) begin : g_busy
      logic busy_q;
      logic busy_d;

      // Issue is applied last so a new producer wins over a retiring one.
      always_comb begin
         busy_d = busy_q;
         if (wr_en && (wr_addr_i == AW'(gi))) busy_d = 1'b0;
         if (iss_en && (iss_addr_i == AW'(gi))) busy_d = 1'b1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) busy_q <= 1'b0;
         else        busy_q <= busy_d;
      end

      assign busy_vec[gi] = busy_q;
   end

   assign set_new = iss_en && !busy_vec[iss_addr_i];
   assign clr_old = wr_en && busy_vec[wr_addr_i] &&
                    !(iss_en && (iss_addr_i == wr_addr_i));

   always_comb begin
      busy_cnt_d = busy_cnt_q;
      unique case ({set_new, clr_old})
         2'b10:   busy_cnt_d = busy_cnt_q + 1'b1;
         2'b01:   busy_cnt_d = busy_cnt_q - 1'b1;
         default: busy_cnt_d = busy_cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_cnt_q <= '0;
      else        busy_cnt_q <= busy_cnt_d;
   end

   assign busy_cnt_o = busy_cnt_q;

   for (gi = 0; gi < NRD; gi++) begin : g_rd
`ifdef GPR_BYPASS_EN
      logic wr_hit;
      logic iss_hit;
      assign wr_hit  = wr_en && (wr_addr_i == rd_addr_i[gi]);
      assign iss_hit = iss_en && (iss_addr_i == rd_addr_i[gi]);
      // A colliding issue keeps the pre-edge busy state visible.
      assign rd_busy_o[gi] = (wr_hit && !iss_hit) ? 1'b0 : busy_vec[rd_addr_i[gi]];
`else
      assign rd_busy_o[gi] = busy_vec[rd_addr_i[gi]];
`endif
   end

endmodule

// File: rtl/gpr_file.sv
// Integer register file (x0 hardwired to zero) with zero-latency read ports and busy scoreboard.
// Define GPR_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module gpr_file
   import gpr_pkg::*;
#(
   parameter  int XLEN = GPR_XLEN,
   parameter  int NREG = GPR_NREG,
   parameter  int NRD  = GPR_NRD,
   localparam int AW   = $clog2(NREG)
) (
   input  logic clk,
   input  logic rst_n,
   gpr_if.slave bus
);

   logic            wr_en;
   logic [XLEN-1:0] rf_view [NREG];

   assign wr_en      = bus.we && (bus.wr_addr != '0);
   assign rf_view[0] = '0;

   genvar gi;
   for (gi = 1; gi < NREG; gi++) begin : g_reg
      logic [XLEN-1:0] reg_q;
      logic [XLEN-1:0] reg_d;

      always_comb begin
         reg_d = reg_q;
         if (wr_en && (bus.wr_addr == AW'(gi))) reg_d = bus.wr_data;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) reg_q <= '0;
         else        reg_q <= reg_d;
      end

      assign rf_view[gi] = reg_q;
   end

   for (gi = 0; gi < NRD; gi++) begin : g_rdp
`ifdef GPR_BYPASS_EN
      assign bus.rd_data[gi] = (wr_en && (bus.wr_addr == bus.rd_addr[gi])) ?
                               bus.wr_data : rf_view[bus.rd_addr[gi]];
`else
      assign bus.rd_data[gi] = rf_view[bus.rd_addr[gi]];
`endif
   end

   gpr_scoreboard #(
      .NREG (NREG),
      .NRD  (NRD)
   ) u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .iss_valid_i (bus.iss_valid),
      .iss_addr_i  (bus.iss_addr),
      .we_i        (bus.we),
      .wr_addr_i   (bus.wr_addr),
      .rd_addr_i   (bus.rd_addr),
      .rd_busy_o   (bus.rd_busy),
      .busy_cnt_o  (bus.busy_cnt)
   );

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: reset, issue/retire, collisions, x0, bypass, async reset mid-stream.
module tb_gpr_file;
   import gpr_pkg::*;

`ifdef GPR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   gpr_if #(.XLEN(64), .NREG(32), .NRD(2)) bus ();

   gpr_file #(.XLEN(64), .NREG(32), .NRD(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input logic iv, input gpr_addr_t ia,
                          input logic w, input gpr_addr_t wa, input gpr_data_t wd);
      bus.iss_valid = iv;
      bus.iss_addr  = ia;
      bus.we        = w;
      bus.wr_addr   = wa;
      bus.wr_data   = wd;
   endtask

   task automatic set_rd(input gpr_addr_t a0, input gpr_addr_t a1);
      bus.rd_addr[0] = a0;
      bus.rd_addr[1] = a1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      set_cmd(1'b0, '0, 1'b0, '0, GPR_ZERO);
      set_rd('0, '0);
      repeat (2) @(posedge clk);
      #1 check("reset_cnt", 64'(bus.busy_cnt), 64'd0);
      @(negedge clk) rst_n = 1'b1;

      // 1: every register on every port after reset
      for (int a = 0; a < 32; a++) begin
         set_rd(5'(a), 5'(31 - a));
         #1;
         check($sformatf("rst_data0_x%0d", a), bus.rd_data[0], 64'd0);
         check($sformatf("rst_data1_x%0d", 31 - a), bus.rd_data[1], 64'd0);
         check($sformatf("rst_busy_x%0d", a), 64'(bus.rd_busy), 64'd0);
      end
      check("rst_cnt_after", 64'(bus.busy_cnt), 64'd0);

      // 2: issue x5, then retire it
      @(negedge clk);
      set_rd(5'd5, 5'd5);
      set_cmd(1'b1, 5'd5, 1'b0, '0, GPR_ZERO);
      #1 check("iss5_pre_busy", 64'(bus.rd_busy[0]), 64'd0);
      @(posedge clk); #1;
      check("iss5_busy", 64'(bus.rd_busy[0]), 64'd1);
      check("iss5_cnt", 64'(bus.busy_cnt), 64'd1);
      @(negedge clk);
      set_cmd(1'b0, '0, 1'b1, 5'd5, 64'hDEAD_BEEF);
      #1;
      check("wr5_pre_busy", 64'(bus.rd_busy[1]), BYP ? 64'd0 : 64'd1);
      check("wr5_pre_data", bus.rd_data[1], BYP ? 64'hDEAD_BEEF : 64'd0);
      @(posedge clk); #1;
      check("wr5_cnt", 64'(bus.busy_cnt), 64'd0);
      check("wr5_busy", 64'(bus.rd_busy[0]), 64'd0);
      @(negedge clk);
      set_cmd(1'b0, '0, 1'b0, '0, GPR_ZERO);
      #1 check("wr5_data", bus.rd_data[0], 64'hDEAD_BEEF);

      // 3: same-cycle issue and write to x7
      @(negedge clk);
      set_rd(5'd7, 5'd7);
      set_cmd(1'b1, 5'd7, 1'b1, 5'd7, 64'h1);
      #1 check("iw7_pre_data", bus.rd_data[0], BYP ? 64'h1 : 64'd0);
      @(posedge clk);
      @(negedge clk);
      set_cmd(1'b0, '0, 1'b0, '0, GPR_ZERO);
      #1;
      check("iw7_data", bus.rd_data[0], 64'h1);
      check("iw7_busy", 64'(bus.rd_busy[1]), 64'd1);
      check("iw7_cnt", 64'(bus.busy_cnt), 64'd1);

      // 4: x0 ignores write and issue
      @(negedge clk);
      set_rd('0, '0);
      set_cmd(1'b1, '0, 1'b1, '0, 64'hFFFF);
      #1 check("x0_pre_data", bus.rd_data[1], 64'd0);
      @(posedge clk);
      @(negedge clk);
      set_cmd(1'b0, '0, 1'b0, '0, GPR_ZERO);
      #1;
      check("x0_data", bus.rd_data[0], 64'd0);
      check("x0_busy", 64'(bus.rd_busy), 64'd0);
      check("x0_cnt", 64'(bus.busy_cnt), 64'd1);

      // 5: write to non-busy x3 while both ports read it
      @(negedge clk);
      set_rd(5'd3, 5'd3);
      set_cmd(1'b0, '0, 1'b1, 5'd3, 64'hA5);
      #1;
      check("byp3_data0", bus.rd_data[0], BYP ? 64'hA5 : 64'd0);
      check("byp3_data1", bus.rd_data[1], BYP ? 64'hA5 : 64'd0);
      @(posedge clk);
      @(negedge clk);
      set_cmd(1'b0, '0, 1'b0, '0, GPR_ZERO);
      set_rd(5'd3, 5'd7);
      #1;
      check("ind_data0", bus.rd_data[0], 64'hA5);
      check("ind_data1", bus.rd_data[1], 64'h1);
      check("ind_busy", 64'(bus.rd_busy), 64'b10);
      check("wr3_cnt", 64'(bus.busy_cnt), 64'd1);

      // write + re-issue of busy x7: busy flag keeps pre-edge state
      @(negedge clk);
      set_rd(5'd7, 5'd7);
      set_cmd(1'b1, 5'd7, 1'b1, 5'd7, 64'h2);
      #1;
      check("rei7_pre_busy", 64'(bus.rd_busy[0]), 64'd1);
      check("rei7_pre_data", bus.rd_data[0], BYP ? 64'h2 : 64'h1);
      @(posedge clk); #1;
      check("rei7_busy", 64'(bus.rd_busy[1]), 64'd1);
      check("rei7_cnt", 64'(bus.busy_cnt), 64'd1);
      check("rei7_data", bus.rd_data[1], 64'h2);
      @(negedge clk);
      set_cmd(1'b0, '0, 1'b1, 5'd7, 64'h3);
      #1 check("ret7_pre_busy", 64'(bus.rd_busy[0]), BYP ? 64'd0 : 64'd1);
      @(posedge clk); #1;
      check("ret7_busy", 64'(bus.rd_busy[0]), 64'd0);
      check("ret7_cnt", 64'(bus.busy_cnt), 64'd0);
      check("ret7_data", bus.rd_data[0], 64'h3);

      // issue to already-busy x9, then issue x10 while retiring x9
      @(negedge clk);
      set_rd(5'd9, 5'd10);
      set_cmd(1'b1, 5'd9, 1'b0, '0, GPR_ZERO);
      @(posedge clk); #1 check("iss9_cnt", 64'(bus.busy_cnt), 64'd1);
      @(posedge clk); #1;
      check("iss9_again_cnt", 64'(bus.busy_cnt), 64'd1);
      check("iss9_again_busy", 64'(bus.rd_busy[0]), 64'd1);
      @(negedge clk);
      set_cmd(1'b1, 5'd10, 1'b1, 5'd9, 64'h99);
      @(posedge clk); #1;
      check("swap_cnt", 64'(bus.busy_cnt), 64'd1);
      check("swap_busy", 64'(bus.rd_busy), 64'b10);
      check("swap_data9", bus.rd_data[0], 64'h99);
      @(negedge clk);
      set_cmd(1'b0, '0, 1'b1, 5'd10, 64'h1010);
      @(posedge clk); #1 check("ret10_cnt", 64'(bus.busy_cnt), 64'd0);
      @(negedge clk);
      set_cmd(1'b0, '0, 1'b0, '0, GPR_ZERO);

      // 6: consecutive issues with an asynchronous reset part-way through
      for (int a = 1; a <= 20; a++) begin
         @(negedge clk);
         set_cmd(1'b1, 5'(a), 1'b0, '0, GPR_ZERO);
         @(posedge clk); #1;
         check($sformatf("seq_cnt_%0d", a), 64'(bus.busy_cnt), 64'(a));
      end
      #2;
      rst_n = 1'b0;
      set_cmd(1'b0, '0, 1'b1, 5'd5, 64'h77);
      #1 check("async_cnt", 64'(bus.busy_cnt), 64'd0);
      for (int a = 0; a < 32; a++) begin
         set_rd(5'(a), 5'(a));
         #1;
         check($sformatf("async_data_x%0d", a), bus.rd_data[0], 64'd0);
         check($sformatf("async_busy_x%0d", a), 64'(bus.rd_busy), 64'd0);
      end
      @(negedge clk);
      set_cmd(1'b0, '0, 1'b0, '0, GPR_ZERO);
      rst_n = 1'b1;
      set_rd(5'd5, 5'd20);
      #1;
      check("rel_data5", bus.rd_data[0], 64'd0);
      check("rel_busy", 64'(bus.rd_busy), 64'd0);
      @(posedge clk); #1 check("rel_cnt", 64'(bus.busy_cnt), 64'd0);

      for (int a = 1; a <= 31; a++) begin
         @(negedge clk);
         set_cmd(1'b1, 5'(a), 1'b0, '0, GPR_ZERO);
         @(posedge clk); #1;
         check($sformatf("fill_cnt_%0d", a), 64'(bus.busy_cnt), 64'(a));
      end
      @(negedge clk);
      set_cmd(1'b0, '0, 1'b0, '0, GPR_ZERO);
      set_rd('0, 5'd31);
      #1 check("fill_busy", 64'(bus.rd_busy), 64'b10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
